operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 154 +++++++++++++++
 tb/tb_operand_fetch.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch
//   Decode-to-execute stage: resolves the two source operands of a decoded
//   instruction from the register file or the EX/MEM/WB forwarding paths. It
//   holds the instruction back while a producer's result is not yet
//   forwardable, and registers the result in a ready/valid output register
//   (the ID/EX register).
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     kill output register, drop current input
//   in_valid / in_ready       decoded instruction handshake
//   in_rs1, in_rs2, in_rd     register specifiers
//   in_ctrl[15:0]             bit0 reg-write, bit1 load, bit2 uses rs1,
//                             bit3 uses rs2, other bits pass through
//   rf_a1, rf_a2              register-file read addresses
//   rf_rd1, rf_rd2            register-file read data
//   ex_fwd_en/ex_fwd_load/ex_rd/ex_data   EX-stage forwarding source
//   mem_fwd_en/mem_rd/mem_data            MEM-stage forwarding source
//   wb_fwd_en/wb_rd/wb_data               WB-stage forwarding source
//   out_valid / out_ready     ID/EX register handshake
//   out_op1, out_op2          resolved operands
//   out_rd, out_ctrl          registered specifier and control
//   stall_cnt[31:0]           saturating count of hazard-stall cycles
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_ctrl,
  output logic [4:0]  rf_a1,
  output logic [4:0]  rf_a2,
  input  logic [63:0] rf_rd1,
  input  logic [63:0] rf_rd2,
  input  logic        ex_fwd_en,
  input  logic        ex_fwd_load,
  input  logic [4:0]  ex_rd,
  input  logic [63:0] ex_data,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_data,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_op1,
  output logic [63:0] out_op2,
  output logic [4:0]  out_rd,
  output logic [15:0] out_ctrl,
  output logic [31:0] stall_cnt
);

  logic        valid_reg;
  logic [63:0] op1_reg;
  logic [63:0] op2_reg;
  logic [4:0]  rd_reg;
  logic [15:0] ctrl_reg;
  logic [31:0] stall_reg;

  // Per-source views so both operands share one generate body.
  logic [1:0][4:0]  src_rs;
  logic [1:0]       src_use;
  logic [1:0][63:0] src_rf;
  logic [1:0][63:0] src_op;
  logic [1:0]       src_hz;

  logic hazard;
  logic transfer;

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  assign src_rs[0]  = in_rs1;
  assign src_rs[1]  = in_rs2;
  assign src_use[0] = in_ctrl[2];
  assign src_use[1] = in_ctrl[3];
  assign src_rf[0]  = rf_rd1;
  assign src_rf[1]  = rf_rd2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic rs_zero;
      logic ex_hit;
      logic ex_load_hit;
      logic mem_hit;
      logic wb_hit;
      logic out_hit;

      // A zero source short-circuits everything, so a forwarding stage with
      // destination x0 can never supply (or block) an operand.
      assign rs_zero     = (src_rs[gi] == 5'd0);
      assign ex_hit      = ex_fwd_en & ~ex_fwd_load & (ex_rd == src_rs[gi]);
      assign ex_load_hit = ex_fwd_en &  ex_fwd_load & (ex_rd == src_rs[gi]);
      assign mem_hit     = mem_fwd_en & (mem_rd == src_rs[gi]);
      assign wb_hit      = wb_fwd_en  & (wb_rd  == src_rs[gi]);
      // The instruction sitting in the output register has no result yet.
      assign out_hit     = valid_reg & ctrl_reg[0] & (rd_reg == src_rs[gi]);

      // Youngest producer wins.
      assign src_op[gi] = rs_zero ? 64'd0    :
                          ex_hit  ? ex_data  :
                          mem_hit ? mem_data :
                          wb_hit  ? wb_data  :
                                    src_rf[gi];

      // Operands that are not used never hold the instruction back.
      assign src_hz[gi] = src_use[gi] & ~rs_zero & (out_hit | ex_load_hit);
    end
  endgenerate

  assign hazard   = in_valid & (|src_hz);
  assign in_ready = ~flush & ~hazard & (~valid_reg | out_ready);
  assign transfer = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      op1_reg   <= '0;
      op2_reg   <= '0;
      rd_reg    <= '0;
      ctrl_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (transfer) begin
      valid_reg <= 1'b1;
      op1_reg   <= src_op[0];
      op2_reg   <= src_op[1];
      rd_reg    <= in_rd;
      ctrl_reg  <= in_ctrl;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (hazard && !flush && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign out_valid = valid_reg;
  assign out_op1   = op1_reg;
  assign out_op2   = op2_reg;
  assign out_rd    = rd_reg;
  assign out_ctrl  = ctrl_reg;
  assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_a1, rf_a2;
  logic [63:0] rf_rd1, rf_rd2;
  logic        ex_fwd_en, ex_fwd_load;
  logic [4:0]  ex_rd;
  logic [63:0] ex_data;
  logic        mem_fwd_en;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic [15:0] out_ctrl;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_stall = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_load(ex_fwd_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_fwd_en(mem_fwd_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_ctrl = 0;
    rf_rd1 = 0; rf_rd2 = 0;
    ex_fwd_en = 0; ex_fwd_load = 0; ex_rd = 0; ex_data = 0;
    mem_fwd_en = 0; mem_rd = 0; mem_data = 0;
    wb_fwd_en = 0; wb_rd = 0; wb_data = 0;
    out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    checks++;
    if ({out_valid, out_op1, out_op2, out_rd, out_ctrl, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b op1=%h op2=%h rd=%0d ctrl=%h stall=%0d, want all 0",
               out_valid, out_op1, out_op2, out_rd, out_ctrl, stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
    $display("reset released");
  endtask

  // Register file says 0x11, MEM forwards 0x22, WB forwards 0x33 for x5.
  task automatic test_mem_over_wb();
    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 5; in_rs2 = 0; in_rd = 3; in_ctrl = 16'h0005;
    rf_rd1 = 64'h11; rf_rd2 = 64'hFFFF;
    mem_fwd_en = 1; mem_rd = 5; mem_data = 64'h22;
    wb_fwd_en = 1; wb_rd = 5; wb_data = 64'h33;
    #1;
    checks++;
    if (rf_a1 !== 5'd5 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mem_fwd_addr_ready: got rf_a1=%0d in_ready=%b want 5/1", rf_a1, in_ready);
    end
    q.push_back('{op1: 64'h22, op2: 64'h0, rd: 5'd3, ctrl: 16'h0005});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL mem_fwd_priority: got v=%b op1=%h op2=%h rd=%0d ctrl=%h want op1=%h op2=%h rd=%0d ctrl=%h",
               out_valid, out_op1, out_op2, out_rd, out_ctrl, e.op1, e.op2, e.rd, e.ctrl);
    end
    $display("xfer mem_over_wb op1=%h", out_op1);
  endtask

  // EX (non-load) beats MEM; x0 stays 0 even with ex_rd=0; unused rs2 hit by
  // an EX load neither stalls nor changes its resolved value.
  task automatic test_ex_priority();
    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 0; in_rs2 = 7; in_rd = 4; in_ctrl = 16'hA00C;
    rf_rd1 = 64'hDEAD; rf_rd2 = 64'h77;
    ex_fwd_en = 1; ex_rd = 7; ex_data = 64'hAA;
    mem_fwd_en = 1; mem_rd = 7; mem_data = 64'hBB;
    q.push_back('{op1: 64'h0, op2: 64'hAA, rd: 5'd4, ctrl: 16'hA00C});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL ex_fwd_priority: got op1=%h op2=%h rd=%0d ctrl=%h want op1=%h op2=%h rd=%0d ctrl=%h",
               out_op1, out_op2, out_rd, out_ctrl, e.op1, e.op2, e.rd, e.ctrl);
    end
    $display("xfer ex_priority op2=%h", out_op2);

    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 0; in_rs2 = 0; in_rd = 2; in_ctrl = 16'h000C;
    rf_rd1 = 64'hBEEF; rf_rd2 = 64'hBEEF;
    ex_fwd_en = 1; ex_rd = 0; ex_data = 64'h99;
    q.push_back('{op1: 64'h0, op2: 64'h0, rd: 5'd2, ctrl: 16'h000C});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL x0_zero: got op1=%h op2=%h rd=%0d want op1=%h op2=%h rd=%0d",
               out_op1, out_op2, out_rd, e.op1, e.op2, e.rd);
    end
    $display("xfer x0 op1=%h op2=%h", out_op1, out_op2);

    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 1; in_rs2 = 12; in_rd = 13; in_ctrl = 16'h0004;
    rf_rd1 = 64'h1111; rf_rd2 = 64'h1234;
    ex_fwd_en = 1; ex_fwd_load = 1; ex_rd = 12; ex_data = 64'hBAD;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL unused_src_no_hazard: got in_ready=%b want 1", in_ready);
    end
    q.push_back('{op1: 64'h1111, op2: 64'h1234, rd: 5'd13, ctrl: 16'h0004});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL unused_src_value: got op1=%h op2=%h want op1=%h op2=%h",
               out_op1, out_op2, e.op1, e.op2);
    end
    $display("xfer unused_src op2=%h", out_op2);
  endtask

  // Load to x9, dependent instruction stalls twice, then picks up mem_data.
  task automatic test_load_hazard();
    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rd = 9; in_ctrl = 16'h0003;
    q.push_back('{op1: 64'h0, op2: 64'h0, rd: 5'd9, ctrl: 16'h0003});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL load_capture: got v=%b rd=%0d ctrl=%h want rd=%0d ctrl=%h",
               out_valid, out_rd, out_ctrl, e.rd, e.ctrl);
    end

    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 9; in_rd = 10; in_ctrl = 16'h0005; rf_rd1 = 64'h5;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_stall_outreg: got in_ready=%b want 0", in_ready);
    end
    exp_stall++;
    @(posedge clk);

    @(negedge clk);
    ex_fwd_en = 1; ex_fwd_load = 1; ex_rd = 9; ex_data = 64'hBAD;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_stall_ex: got in_ready=%b want 0", in_ready);
    end
    exp_stall++;
    @(posedge clk);

    @(negedge clk);
    ex_fwd_en = 0; ex_fwd_load = 0; ex_rd = 0;
    mem_fwd_en = 1; mem_rd = 9; mem_data = 64'h9999;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_release: got in_ready=%b want 1", in_ready);
    end
    q.push_back('{op1: 64'h9999, op2: 64'h0, rd: 5'd10, ctrl: 16'h0005});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL load_dependent: got op1=%h rd=%0d want op1=%h rd=%0d",
               out_op1, out_rd, e.op1, e.rd);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++;
      $display("FAIL stall_count: got %0d want %0d", stall_cnt, exp_stall);
    end
    $display("xfer load_dependent op1=%h stall_cnt=%0d", out_op1, stall_cnt);
  endtask

  // Output held under back-pressure, then the waiting instruction moves in.
  task automatic test_back_pressure();
    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 20; in_rd = 4; in_ctrl = 16'h0105; rf_rd1 = 64'hA0A0;
    q.push_back('{op1: 64'hA0A0, op2: 64'h0, rd: 5'd4, ctrl: 16'h0105});
    @(posedge clk); #1;

    @(negedge clk);
    idle_inputs();
    out_ready = 0;
    in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rd = 11; in_ctrl = 16'h020C;
    rf_rd1 = 64'hB1; rf_rd2 = 64'hB2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      @(posedge clk); #1;
      e = q[0];
      checks++;
      if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got v=%b op1=%h rd=%0d ctrl=%h want op1=%h rd=%0d ctrl=%h",
                 i, out_valid, out_op1, out_rd, out_ctrl, e.op1, e.rd, e.ctrl);
      end
      $display("hold cycle %0d op1=%h", i, out_op1);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
    void'(q.pop_front());
    q.push_back('{op1: 64'hB1, op2: 64'hB2, rd: 5'd11, ctrl: 16'h020C});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL after_release: got op1=%h op2=%h rd=%0d want op1=%h op2=%h rd=%0d",
               out_op1, out_op2, out_rd, e.op1, e.op2, e.rd);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++;
      $display("FAIL backpressure_not_stall: got stall_cnt=%0d want %0d", stall_cnt, exp_stall);
    end
    $display("xfer after_release op1=%h op2=%h", out_op1, out_op2);
  endtask

  // Flush kills the output register and drops a (hazarding) input.
  task automatic test_flush();
    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rd = 6; in_ctrl = 16'h0001;
    q.push_back('{op1: 64'h0, op2: 64'h0, rd: 5'd6, ctrl: 16'h0001});
    @(posedge clk); #1;

    @(negedge clk);
    idle_inputs();
    out_ready = 0; flush = 1;
    in_valid = 1; in_rs1 = 6; in_rd = 14; in_ctrl = 16'h0005; rf_rd1 = 64'hCC;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    void'(q.pop_front());
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_kill: got out_valid=%b want 0", out_valid);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++;
      $display("FAIL flush_no_stall: got stall_cnt=%0d want %0d", stall_cnt, exp_stall);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_capture: got out_valid=%b want 0", out_valid);
    end
    $display("flush done out_valid=%b", out_valid);
  endtask

  // Asynchronous reset in the middle of a cycle, then first capture after release.
  task automatic test_reset_mid();
    @(negedge clk);
    idle_inputs();
    in_valid = 1; in_rs1 = 10; in_rd = 8; in_ctrl = 16'h00F4; rf_rd1 = 64'h5555;
    q.push_back('{op1: 64'h5555, op2: 64'h0, rd: 5'd8, ctrl: 16'h00F4});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL pre_reset_capture: got op1=%h rd=%0d want op1=%h rd=%0d",
               out_op1, out_rd, e.op1, e.rd);
    end

    @(negedge clk);
    in_rs1 = 11; in_rd = 15; in_ctrl = 16'h0004; rf_rd1 = 64'h6666;
    #2;
    rst = 1;
    #1;
    checks++;
    if ({out_valid, out_op1, out_op2, out_rd, out_ctrl, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b op1=%h op2=%h rd=%0d ctrl=%h stall=%0d want all 0",
               out_valid, out_op1, out_op2, out_rd, out_ctrl, stall_cnt);
    end
    exp_stall = 0;
    q.delete();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_capture: got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    rst = 0;
    q.push_back('{op1: 64'h6666, op2: 64'h0, rd: 5'd15, ctrl: 16'h0004});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_op1, out_op2, out_rd, out_ctrl} !== e) begin
      failures++;
      $display("FAIL post_reset_capture: got v=%b op1=%h rd=%0d want op1=%h rd=%0d",
               out_valid, out_op1, out_rd, e.op1, e.rd);
    end
    $display("xfer post_reset op1=%h", out_op1);
  endtask

  initial begin
    test_reset();
    test_mem_over_wb();
    test_ex_priority();
    test_load_hazard();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    @(negedge clk);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
